// File: rtl/video_effect_ctrl.sv
// Frame-synchronous effect scheduler and two-stage pixel pipeline for the video path.
// Mode changes (requested or auto-cycled) are committed only at frame boundaries.
module video_effect_ctrl #(
  parameter bit          VSYNC_POL       = 1'b1,
  parameter int unsigned DEFAULT_MODE    = 0,
  parameter int unsigned FRAMES_PER_MODE = 60,
  parameter int unsigned THRESH          = 128
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_VDE,
  input  logic        i_HSYNC,
  input  logic        i_VSYNC,
  input  logic [23:0] i_pixelData,
  input  logic [1:0]  i_modeReq,
  input  logic        i_modeValid,
  output logic        o_modeAck,
  output logic        o_pending,
  input  logic        i_autoEn,
  output logic        o_VDE,
  output logic        o_HSYNC,
  output logic        o_VSYNC,
  output logic [23:0] o_pixelData,
  output logic [1:0]  o_curMode,
  output logic [15:0] o_frameCnt
);

  localparam logic [1:0]  ResetMode = 2'(DEFAULT_MODE);
  localparam logic [15:0] LastCnt   = 16'(FRAMES_PER_MODE - 1);
  localparam logic [8:0]  ThreshW   = 9'(THRESH);

  typedef enum logic [0:0] {StWaitFrame, StRun} state_e;

  state_e      state_q;
  logic        vsync_prev_q;
  logic        ack_q;
  logic        pending_q;
  logic [1:0]  req_mode_q;
  logic [1:0]  cur_mode_q;
  logic [15:0] auto_cnt_q;
  logic [15:0] frame_cnt_q;

  logic frame_b;
  logic accept;

  assign frame_b = (i_VSYNC == VSYNC_POL) && (vsync_prev_q != VSYNC_POL);
  assign accept  = i_modeValid && !ack_q;

  // Control FSM. Acceptance is applied after the commit so a request landing on
  // a frame boundary survives as pending for the next one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= StWaitFrame;
      vsync_prev_q <= VSYNC_POL;
      ack_q        <= 1'b0;
      pending_q    <= 1'b0;
      req_mode_q   <= 2'd0;
      cur_mode_q   <= ResetMode;
      auto_cnt_q   <= 16'd0;
      frame_cnt_q  <= 16'd0;
    end else begin
      vsync_prev_q <= i_VSYNC;
      ack_q        <= accept;
      if (frame_b) begin
        state_q     <= StRun;
        frame_cnt_q <= frame_cnt_q + 16'd1;
        if (pending_q) begin
          cur_mode_q <= req_mode_q;
          pending_q  <= 1'b0;
          auto_cnt_q <= 16'd0;
        end else if (i_autoEn) begin
          if (auto_cnt_q >= LastCnt) begin
            cur_mode_q <= cur_mode_q + 2'd1;
            auto_cnt_q <= 16'd0;
          end else begin
            auto_cnt_q <= auto_cnt_q + 16'd1;
          end
        end
      end
      if (accept) begin
        req_mode_q <= i_modeReq;
        pending_q  <= 1'b1;
      end
    end
  end

  assign o_modeAck  = ack_q;
  assign o_pending  = pending_q;
  assign o_curMode  = cur_mode_q;
  assign o_frameCnt = frame_cnt_q;

  // Luma weights sum to 256, so the 16-bit accumulator cannot overflow.
  logic [15:0] luma_acc;
  logic [7:0]  luma;

  assign luma_acc = 16'd77  * {8'd0, i_pixelData[23:16]}
                  + 16'd150 * {8'd0, i_pixelData[7:0]}
                  + 16'd29  * {8'd0, i_pixelData[15:8]};
  assign luma     = 8'(luma_acc >> 8);

  logic        s1_vde_q;
  logic        s1_hsync_q;
  logic        s1_vsync_q;
  logic [23:0] s1_pix_q;
  logic [7:0]  s1_luma_q;
  logic [1:0]  s1_mode_q;
  logic [23:0] effect_pix;

  always_comb begin
    effect_pix = s1_pix_q;
    unique case (s1_mode_q)
      2'd0: effect_pix = s1_pix_q;
      2'd1: effect_pix = ~s1_pix_q;
      2'd2: effect_pix = {3{s1_luma_q}};
      2'd3: effect_pix = ({1'b0, s1_luma_q} >= ThreshW) ? 24'hFFFFFF : 24'h000000;
    endcase
  end

  // Stage 1 captures the mode with the pixel, so a boundary commit never splits a frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vde_q    <= 1'b0;
      s1_hsync_q  <= 1'b0;
      s1_vsync_q  <= 1'b0;
      s1_pix_q    <= 24'd0;
      s1_luma_q   <= 8'd0;
      s1_mode_q   <= 2'd0;
      o_VDE       <= 1'b0;
      o_HSYNC     <= 1'b0;
      o_VSYNC     <= 1'b0;
      o_pixelData <= 24'd0;
    end else begin
      s1_vde_q    <= i_VDE && (state_q == StRun);
      s1_hsync_q  <= i_HSYNC;
      s1_vsync_q  <= i_VSYNC;
      s1_pix_q    <= i_pixelData;
      s1_luma_q   <= luma;
      s1_mode_q   <= cur_mode_q;
      o_VDE       <= s1_vde_q;
      o_HSYNC     <= s1_hsync_q;
      o_VSYNC     <= s1_vsync_q;
      o_pixelData <= s1_vde_q ? effect_pix : 24'd0;
    end
  end

endmodule

// File: tb/tb_video_effect_ctrl.sv
// Self-checking bench for video_effect_ctrl: scenario tasks compared against a
// frame-level behavioural model (expected-output queue plus mode/commit bookkeeping).
module tb_video_effect_ctrl;

  localparam int FPM       = 2;
  localparam int FRAME_LEN = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vde_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic [23:0] pix_in = 24'd0;
  logic [1:0]  req_in = 2'd0;
  logic        valid_in = 1'b0, auto_in = 1'b0;
  logic        o_modeAck, o_pending, o_VDE, o_HSYNC, o_VSYNC;
  logic [23:0] o_pixelData;
  logic [1:0]  o_curMode;
  logic [15:0] o_frameCnt;

  always #5 clk = ~clk;

  video_effect_ctrl #(
    .VSYNC_POL      (1'b1),
    .DEFAULT_MODE   (0),
    .FRAMES_PER_MODE(FPM),
    .THRESH         (128)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_VDE      (vde_in),
    .i_HSYNC    (hs_in),
    .i_VSYNC    (vs_in),
    .i_pixelData(pix_in),
    .i_modeReq  (req_in),
    .i_modeValid(valid_in),
    .o_modeAck  (o_modeAck),
    .o_pending  (o_pending),
    .i_autoEn   (auto_in),
    .o_VDE      (o_VDE),
    .o_HSYNC    (o_HSYNC),
    .o_VSYNC    (o_VSYNC),
    .o_pixelData(o_pixelData),
    .o_curMode  (o_curMode),
    .o_frameCnt (o_frameCnt)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct packed {logic vde; logic hs; logic vs; logic [23:0] pix;} vid_t;
  vid_t pipe[2];  // pipe[1] is what the outputs must show now
  bit   m_run, m_prev_vs, m_pending, m_ack;
  int   m_mode, m_req, m_frames_in_mode, m_fcnt;

  function automatic logic [23:0] ref_effect(input int mode, input logic [23:0] p);
    int r, g, b, y;
    r = int'(p[23:16]);
    b = int'(p[15:8]);
    g = int'(p[7:0]);
    y = (77 * r + 150 * g + 29 * b) / 256;
    case (mode)
      0:       return p;
      1:       return ~p;
      2:       return {y[7:0], y[7:0], y[7:0]};
      default: return (y >= 128) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  function automatic logic [19:0] exp_ctl();
    logic [1:0]  md;
    logic [15:0] fc;
    md = m_mode[1:0];
    fc = m_fcnt[15:0];
    return {md, m_pending, m_ack, fc};
  endfunction

  task automatic model_reset();
    pipe[0] = '0;
    pipe[1] = '0;
    m_run = 0; m_prev_vs = 1; m_pending = 0; m_ack = 0;
    m_mode = 0; m_req = 0; m_frames_in_mode = 0; m_fcnt = 0;
  endtask

  task automatic model_step();
    vid_t e;
    bit   fb, acc;
    e.vde = vde_in & m_run;
    e.hs  = hs_in;
    e.vs  = vs_in;
    e.pix = e.vde ? ref_effect(m_mode, pix_in) : 24'd0;
    pipe[1] = pipe[0];
    pipe[0] = e;
    fb = vs_in && !m_prev_vs;
    m_prev_vs = vs_in;
    acc = valid_in && !m_ack;
    m_ack = acc;
    if (fb) begin
      m_run = 1;
      m_fcnt = (m_fcnt + 1) % 65536;
      if (m_pending) begin
        m_mode = m_req; m_pending = 0; m_frames_in_mode = 0;
      end else if (auto_in) begin
        m_frames_in_mode++;
        if (m_frames_in_mode == FPM) begin
          m_mode = (m_mode + 1) % 4;
          m_frames_in_mode = 0;
        end
      end
    end
    if (acc) begin
      m_req = int'(req_in);
      m_pending = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  // Frame raster: 2 vsync cycles, then 12-cycle lines with 6 active pixels each.
  task automatic drive(input int c, input bit use_fixed, input logic [23:0] fixed);
    int p;
    p = (c >= 4) ? (c - 4) % 12 : 0;
    vs_in  = (c < 2);
    hs_in  = (c >= 4) && (p < 2);
    vde_in = (c >= 4) && (p >= 4) && (p < 10);
    pix_in = use_fixed ? fixed : 24'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData, o_curMode, o_pending, o_modeAck, o_frameCnt}
        !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs got vde=%b mode=%0d fc=%0d pix=%h want all zero",
               o_VDE, o_curMode, o_frameCnt, o_pixelData);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(20, 1'b1, 24'hFF8040);
      vde_in = 1'b1;
      tick();
      checks++;
      if (o_VDE !== 1'b0) begin
        errors++; $display("FAIL pre_fb_vde got %b want 0", o_VDE);
      end
      checks++;
      if ({o_curMode, o_pending, o_modeAck, o_frameCnt} !== exp_ctl()) begin
        errors++; $display("FAIL pre_fb_ctl got %h want %h",
                           {o_curMode, o_pending, o_modeAck, o_frameCnt}, exp_ctl());
      end
    end
  endtask

  task automatic test_first_frame();
    for (int c = 0; c < FRAME_LEN; c++) begin
      drive(c, 1'b1, 24'hFF8040);
      tick();
      checks++;
      if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData} !== pipe[1]) begin
        errors++; $display("FAIL first_video c=%0d got %h want %h", c,
                           {o_VDE, o_HSYNC, o_VSYNC, o_pixelData}, pipe[1]);
      end
      if (pipe[1].vde) begin
        checks++;
        if (o_pixelData !== 24'hFF8040) begin
          errors++; $display("FAIL first_pixel got %h want ff8040", o_pixelData);
        end
      end
    end
    checks++;
    if (o_frameCnt !== 16'd1) begin
      errors++; $display("FAIL first_framecnt got %0d want 1", o_frameCnt);
    end
  endtask

  task automatic test_negative();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        drive(c, 1'b1, 24'h123456);
        if (f == 0 && c == 10) begin req_in = 2'd1; valid_in = 1'b1; end
        tick();
        checks++;
        if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData} !== pipe[1]) begin
          errors++; $display("FAIL neg_video f=%0d c=%0d got %h want %h", f, c,
                             {o_VDE, o_HSYNC, o_VSYNC, o_pixelData}, pipe[1]);
        end
        if (f == 0 && c == 10) begin
          valid_in = 1'b0;
          checks++;
          if ({o_modeAck, o_pending} !== 2'b11) begin
            errors++; $display("FAIL neg_ack got ack=%b pend=%b want 1 1", o_modeAck, o_pending);
          end
        end
        if (f == 0 && c == 11) begin
          checks++;
          if (o_modeAck !== 1'b0) begin
            errors++; $display("FAIL neg_ack_pulse got %b want 0", o_modeAck);
          end
        end
        if (f == 1 && c == 0) begin
          checks++;
          if ({o_curMode, o_pending} !== {2'd1, 1'b0}) begin
            errors++; $display("FAIL neg_commit got mode=%0d pend=%b want 1 0",
                               o_curMode, o_pending);
          end
        end
        if (pipe[1].vde) begin
          checks++;
          if (o_pixelData !== ((f == 0) ? 24'h123456 : 24'hEDCBA9)) begin
            errors++; $display("FAIL neg_pixel f=%0d got %h want %h", f, o_pixelData,
                               (f == 0) ? 24'h123456 : 24'hEDCBA9);
          end
        end
      end
    end
  endtask

  task automatic test_gray_thresh();
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        drive(c, f > 0, 24'hC83264);
        if (f < 2 && c == 10) begin req_in = (f == 0) ? 2'd2 : 2'd3; valid_in = 1'b1; end
        tick();
        checks++;
        if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData} !== pipe[1]) begin
          errors++; $display("FAIL gray_video f=%0d c=%0d got %h want %h", f, c,
                             {o_VDE, o_HSYNC, o_VSYNC, o_pixelData}, pipe[1]);
        end
        if (f < 2 && c == 10) valid_in = 1'b0;
        if (f > 0 && pipe[1].vde) begin
          checks++;
          if (o_pixelData !== ((f == 1) ? 24'h7C7C7C : 24'h000000)) begin
            errors++; $display("FAIL gray_pixel f=%0d got %h want %h", f, o_pixelData,
                               (f == 1) ? 24'h7C7C7C : 24'h000000);
          end
        end
      end
    end
  endtask

  task automatic test_auto_cycle();
    logic [1:0] want [6];
    want = '{2'd0, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1};
    for (int f = 0; f < 6; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        drive(c, 1'b0, 24'd0);
        if (f == 0 && c == 10) begin req_in = 2'd3; valid_in = 1'b1; end
        tick();
        if (f == 0 && c == 10) valid_in = 1'b0;
        checks++;
        if ({o_curMode, o_pending, o_modeAck, o_frameCnt} !== exp_ctl()) begin
          errors++; $display("FAIL auto_ctl f=%0d c=%0d got %h want %h", f, c,
                             {o_curMode, o_pending, o_modeAck, o_frameCnt}, exp_ctl());
        end
        if (f > 0 && c == 0) begin
          checks++;
          if (o_curMode !== want[f]) begin
            errors++; $display("FAIL auto_mode f=%0d got %0d want %0d", f, o_curMode, want[f]);
          end
          if (f == 1) auto_in = 1'b1;
        end
      end
    end
    auto_in = 1'b0;
  endtask

  task automatic test_same_cycle_fb();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < FRAME_LEN; c++) begin
        drive(c, 1'b0, 24'd0);
        if (f == 0 && c == 0) begin req_in = 2'd2; valid_in = 1'b1; end
        tick();
        checks++;
        if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData} !== pipe[1]) begin
          errors++; $display("FAIL same_video f=%0d c=%0d got %h want %h", f, c,
                             {o_VDE, o_HSYNC, o_VSYNC, o_pixelData}, pipe[1]);
        end
        if (c == 0) begin
          valid_in = 1'b0;
          checks++;
          if ({o_curMode, o_pending} !== ((f == 0) ? {2'd1, 1'b1} : {2'd2, 1'b0})) begin
            errors++; $display("FAIL same_commit f=%0d got mode=%0d pend=%b", f, o_curMode,
                               o_pending);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      auto_in = 1'($urandom);
      for (int c = 0; c < FRAME_LEN; c++) begin
        drive(c, 1'b0, 24'd0);
        valid_in = ($urandom_range(0, 7) == 0);
        req_in   = 2'($urandom);
        tick();
        checks++;
        if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData} !== pipe[1]) begin
          errors++; $display("FAIL rand_video f=%0d c=%0d got %h want %h", f, c,
                             {o_VDE, o_HSYNC, o_VSYNC, o_pixelData}, pipe[1]);
        end
        checks++;
        if ({o_curMode, o_pending, o_modeAck, o_frameCnt} !== exp_ctl()) begin
          errors++; $display("FAIL rand_ctl f=%0d c=%0d got %h want %h", f, c,
                             {o_curMode, o_pending, o_modeAck, o_frameCnt}, exp_ctl());
        end
      end
    end
    valid_in = 1'b0;
    auto_in  = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 21; c++) begin
      drive(c, 1'b0, 24'd0);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData, o_curMode, o_pending, o_modeAck, o_frameCnt}
        !== 47'd0) begin
      errors++;
      $display("FAIL async_reset got vde=%b mode=%0d fc=%0d pix=%h want all zero",
               o_VDE, o_curMode, o_frameCnt, o_pixelData);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 22; c < FRAME_LEN + 10; c++) begin
      drive(22 + (c % 6), 1'b0, 24'd0);
      vde_in = 1'b1;
      tick();
      checks++;
      if (o_VDE !== 1'b0) begin
        errors++; $display("FAIL post_reset_vde got %b want 0", o_VDE);
      end
    end
    for (int c = 0; c < FRAME_LEN; c++) begin
      drive(c, 1'b0, 24'd0);
      tick();
      checks++;
      if ({o_VDE, o_HSYNC, o_VSYNC, o_pixelData} !== pipe[1]) begin
        errors++; $display("FAIL post_reset_video c=%0d got %h want %h", c,
                           {o_VDE, o_HSYNC, o_VSYNC, o_pixelData}, pipe[1]);
      end
    end
    checks++;
    if ({o_curMode, o_frameCnt} !== {2'd0, 16'd1}) begin
      errors++; $display("FAIL post_reset_ctl got mode=%0d fc=%0d want 0 1", o_curMode,
                         o_frameCnt);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_frame();
    test_negative();
    test_gray_thresh();
    test_auto_cycle();
    test_same_cycle_fb();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_effect_ctrl.md
Name: video_effect_ctrl

Overview:
- Frame-synchronous effect scheduler and pixel pipeline for the HDMI/DVI video path, placed between the video input timing source and the output encoder.
- Selects one of four per-pixel effects: passthrough, negative, grayscale, binary threshold.
- Mode changes come from a request handshake or an auto-cycle timer. Changes take effect only on frame boundaries, so no frame is ever processed with mixed effects.
- Pixel format is {R[23:16], B[15:8], G[7:0]}.

Parameters:
- VSYNC_POL, 1, active level of i_VSYNC (1 = active-high)
- DEFAULT_MODE, 0, mode loaded at reset (0 pass, 1 neg, 2 gray, 3 thresh)
- FRAMES_PER_MODE, 60, frames per mode when auto-cycle is on; legal range 1..65535
- THRESH, 128, grayscale threshold for mode 3

Ports:
- i_clk  input  1  pixel clock
- i_rst  input  1  reset; asynchronous, active-high
- i_VDE  input  1  video data enable
- i_HSYNC  input  1  horizontal sync
- i_VSYNC  input  1  vertical sync
- i_pixelData  input  24  input pixel
- i_modeReq  input  2  requested mode
- i_modeValid  input  1  mode request valid
- o_modeAck  output  1  one-cycle pulse: request accepted
- o_pending  output  1  accepted request waiting for a frame boundary
- i_autoEn  input  1  enable auto-cycle
- o_VDE  output  1  delayed data enable
- o_HSYNC  output  1  delayed horizontal sync
- o_VSYNC  output  1  delayed vertical sync
- o_pixelData  output  24  processed pixel
- o_curMode  output  2  mode currently applied
- o_frameCnt  output  16  frame boundary counter

Behaviour:
- Reset (async, i_rst=1):
  - All outputs go to 0, except o_curMode = DEFAULT_MODE.
  - Internal pending register cleared, auto counter = 0, state = WAIT_FRAME.
  - Reset asserted mid-frame takes effect immediately; the output frame is truncated.
- Frame boundary (FB): the clock edge at which i_VSYNC transitions to its active level (VSYNC_POL), detected with a registered previous-sample.
- States:
  - WAIT_FRAME: o_VDE forced 0, o_pixelData 0, syncs still delayed and passed. Go to RUN on the first FB.
  - RUN: normal operation.
- Request handshake:
  - When i_modeValid=1 and o_modeAck=0, latch i_modeReq, set pending, and pulse o_modeAck for one cycle on the next cycle.
  - The requester must drop i_modeValid after seeing the ack; a held valid is re-accepted every other cycle.
  - A new request while pending overwrites the latched mode and is acked again.
  - Requests are accepted in WAIT_FRAME too.
- Commit at each FB, in this priority order:
  1. If pending: o_curMode <= latched mode, pending cleared, auto counter cleared.
  2. Else if i_autoEn: counter increments. When counter reaches FRAMES_PER_MODE-1, o_curMode <= o_curMode+1 (wrapping 3 to 0) and counter clears.
  3. Else: no change.
- Request and FB on the same cycle: the FB commits the old pending state only. The new request commits at the following FB.
- i_autoEn=0: counter holds its value; it is not cleared.
- o_frameCnt increments at every FB, including the first; wraps 65535 to 0.
- Pipeline: fixed 2-cycle latency from inputs to o_VDE, o_HSYNC, o_VSYNC and o_pixelData. No bubbles and no stalls.
  - Stage 1 registers the pixel, the syncs, and the luma Y = (77*R + 150*G + 29*B) >> 8, using a 16-bit accumulator; max 65280, no overflow.
  - Stage 2 applies the mode that was current when the pixel entered stage 1:
    - mode 0: pixel unchanged
    - mode 1: bitwise invert of all 24 bits
    - mode 2: {Y,Y,Y}
    - mode 3: 24'hFFFFFF if Y >= THRESH, else 0
  - o_pixelData = 0 whenever o_VDE = 0.
- o_curMode updates at FB. The first pixel of a frame enters the pipeline after FB, so a whole frame always uses one mode.

Test Plan:
- Reset, then drive VSYNC edge and a pixel 24'hFF8040 in mode 0 -> o_VDE stays 0 before the first FB; after it, o_pixelData = 24'hFF8040 two cycles after input; o_frameCnt = 1.
- Request mode 1 mid-frame -> o_modeAck pulses once, o_pending=1, pixels stay unchanged until FB; after FB, input 24'h123456 produces 24'hEDCBA9 and o_pending=0.
- Mode 2 with pixel R=200, B=50, G=100 -> Y=(15400+15000+1450)>>8=124, o_pixelData = 24'h7C7C7C. Mode 3 with the same pixel and THRESH=128 -> 24'h000000.
- i_autoEn=1, FRAMES_PER_MODE=2, start at mode 3 -> o_curMode follows 3,3,0,0,1 over successive FBs; wrap verified.
- Request asserted on the same cycle as FB -> o_curMode unchanged at that FB, updated at the next FB.
- Assert i_rst mid-frame -> all outputs go to 0 immediately without a clock edge; o_curMode = DEFAULT_MODE; o_VDE stays low until the next FB.
